// File: rtl/mult_pkg.sv
// Shared types and constants for the partial-product stage sequencer.
// Holds the FSM state encoding, the enable-mode constants and the index-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_CUMULATIVE = 1'b0;
  localparam logic MODE_ONEHOT     = 1'b1;

  // A single-stage sequencer still needs a one-bit index port.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_dwell_counter.sv
// 8-bit dwell counter that measures how long the current stage has been held.
// Flags the terminal count so the sequencer knows when to advance.
module mult_dwell_counter #(
  parameter int unsigned TERMINAL = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [7:0] TC = 8'(TERMINAL);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = (r_count == TC);

endmodule

// File: rtl/mult_sequencer.sv
// Sequences NUM_STAGES partial-product stages, holding each for STAGE_CYCLES
// unstalled cycles, and drives cumulative or one-hot stage enables.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_CYCLES = 1,
  localparam int IDX_W       = idxWidth(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  input  logic                  mode,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  done_pulse
);

  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_stage;
  logic [IDX_W-1:0] w_nextStage;
  logic             r_mode;
  logic             w_nextMode;
  logic             r_donePulse;
  logic             w_dwellTc;
  logic             w_advance;
  logic             w_dwellClear;
  logic             w_dwellEnable;

  assign w_dwellClear  = abort || (r_state != RUN) || w_advance;
  assign w_dwellEnable = (r_state == RUN) && !stall;

  mult_dwell_counter #(
    .TERMINAL (STAGE_CYCLES - 1)
  ) u_dwell (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_dwellClear),
    .i_enable   (w_dwellEnable),
    .o_terminal (w_dwellTc)
  );

  always_comb begin
    w_nextState = r_state;
    w_nextStage = r_stage;
    w_nextMode  = r_mode;
    w_advance   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState = RUN;
          w_nextStage = '0;
          w_nextMode  = mode;
        end
      end
      RUN: begin
        if (!stall && w_dwellTc) begin
          w_advance = 1'b1;
          if (r_stage == LAST_STAGE) begin
            w_nextState = DONE;
            w_nextStage = '0;
          end else begin
            w_nextStage = r_stage + IDX_W'(1);
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextStage = '0;
      end
    endcase
    // Abort outranks both start and stall.
    if (abort) begin
      w_nextState = IDLE;
      w_nextStage = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      r_mode      <= MODE_CUMULATIVE;
      r_donePulse <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_stage     <= w_nextStage;
      r_mode      <= w_nextMode;
      r_donePulse <= (w_nextState == DONE) && (r_state != DONE);
    end
  end

  // Enables decode purely from registered state, stage and latched mode.
  always_comb begin
    stage_en = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      case (r_state)
        RUN:     stage_en[i] = (r_mode == MODE_ONEHOT) ? (i == int'(r_stage))
                                                       : (i <= int'(r_stage));
        DONE:    stage_en[i] = (r_mode == MODE_CUMULATIVE);
        default: stage_en[i] = 1'b0;
      endcase
    end
  end

  assign stage_idx  = r_stage;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign done_pulse = r_donePulse;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: three parameterisations share the same
// inputs; each phase pushes expected output words and pops them per cycle.
module tb_mult_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic abort;
  logic stall;
  logic mode;

  logic [3:0] en41, en43;
  logic [1:0] idx41, idx43;
  logic       busy41, done41, pulse41;
  logic       busy43, done43, pulse43;
  logic [1:0] en21;
  logic [0:0] idx21;
  logic       busy21, done21, pulse21;

  int checks   = 0;
  int failures = 0;

  // Packed word: {stage_en[3:0], stage_idx[1:0], busy, done, done_pulse}
  logic [8:0] expQ[$];

  always #5 clk = ~clk;

  mult_sequencer #(.NUM_STAGES(4), .STAGE_CYCLES(1)) dut41 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .stall(stall), .mode(mode),
    .stage_en(en41), .stage_idx(idx41), .busy(busy41), .done(done41), .done_pulse(pulse41));

  mult_sequencer #(.NUM_STAGES(4), .STAGE_CYCLES(3)) dut43 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .stall(stall), .mode(mode),
    .stage_en(en43), .stage_idx(idx43), .busy(busy43), .done(done43), .done_pulse(pulse43));

  mult_sequencer #(.NUM_STAGES(2), .STAGE_CYCLES(1)) dut21 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .stall(stall), .mode(mode),
    .stage_en(en21), .stage_idx(idx21), .busy(busy21), .done(done21), .done_pulse(pulse21));

  function automatic logic [8:0] observe(input int sel);
    case (sel)
      0:       return {en41, idx41, busy41, done41, pulse41};
      1:       return {en43, idx43, busy43, done43, pulse43};
      default: return {2'b00, en21, 1'b0, idx21, busy21, done21, pulse21};
    endcase
  endfunction

  // p = unstalled cycles elapsed since the start edge.
  function automatic logic [8:0] expRun(input int n, input int sc, input bit m, input int p);
    int k;
    logic [3:0] en;
    k = p / sc;
    if (k < n) begin
      en = m ? 4'(1 << k) : 4'((1 << (k + 1)) - 1);
      return {en, 2'(k), 1'b1, 1'b0, 1'b0};
    end
    en = m ? 4'b0000 : 4'((1 << n) - 1);
    return {en, 2'b00, 1'b0, 1'b1, (p == n * sc)};
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b (en,idx,busy,done,pulse)", tag, obs, exp);
    end
  endtask

  task automatic popAndCheck(input string tag, input int sel);
    logic [8:0] exp;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      exp = expQ.pop_front();
      checkOutput(tag, observe(sel), exp);
    end
  endtask

  // Called just after a falling edge; start is taken on the next rising edge.
  task automatic applyStimulus(input string tag, input int sel, input int n, input int sc,
                               input bit m, input int stLo, input int stHi, input int ncyc);
    int stalls = 0;
    start = 1'b1;
    mode  = m;
    stall = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      expQ.push_back(expRun(n, sc, m, (c - 1) - stalls));
      @(negedge clk);
      popAndCheck($sformatf("%s_c%0d", tag, c), sel);
      start = 1'b0;
      stall = (c >= stLo) && (c <= stHi);
      if (stall) stalls++;
    end
    stall = 1'b0;
  endtask

  task automatic idleAll();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    stall   = 1'b0;
    mode    = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      expQ.push_back(9'b0);
      popAndCheck($sformatf("reset_dut%0d", s), s);
    end
    reset_n = 1'b1;

    applyStimulus("cumul", 0, 4, 1, 1'b0, 0, -1, 8);
    applyStimulus("restart", 0, 4, 1, 1'b1, 0, -1, 6);

    idleAll();
    expQ.push_back(9'b0);
    popAndCheck("abort_idle", 1);
    applyStimulus("onehot3", 1, 4, 3, 1'b1, 0, -1, 16);

    idleAll();
    applyStimulus("stall", 0, 4, 1, 1'b0, 2, 3, 9);

    // Abort together with start mid-run must win and leave no done_pulse.
    idleAll();
    start = 1'b1;
    mode  = 1'b0;
    expQ.push_back(expRun(4, 1, 1'b0, 0));
    @(negedge clk);
    popAndCheck("abort_c1", 0);
    start = 1'b0;
    expQ.push_back(expRun(4, 1, 1'b0, 1));
    @(negedge clk);
    popAndCheck("abort_c2", 0);
    abort = 1'b1;
    start = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      expQ.push_back(9'b0);
      @(negedge clk);
      popAndCheck($sformatf("abort_c%0d", c), 0);
      abort = 1'b0;
      start = 1'b0;
    end
    applyStimulus("after_abort", 0, 4, 1, 1'b0, 0, -1, 6);

    // Reset mid-run at stage 2 clears outputs without waiting for a clock.
    idleAll();
    start = 1'b1;
    mode  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    expQ.push_back(expRun(4, 1, 1'b0, 2));
    popAndCheck("rst_pre", 0);
    #1 reset_n = 1'b0;
    #1;
    expQ.push_back(9'b0);
    popAndCheck("rst_async", 0);
    @(negedge clk);
    expQ.push_back(9'b0);
    popAndCheck("rst_hold", 0);
    reset_n = 1'b1;
    applyStimulus("rst_post", 0, 4, 1, 1'b0, 0, -1, 6);

    // Start held high: ignored in RUN, restart after each DONE cycle.
    idleAll();
    start = 1'b1;
    mode  = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      case ((c - 1) % 3)
        0:       expQ.push_back({4'b0001, 2'b00, 1'b1, 1'b0, 1'b0});
        1:       expQ.push_back({4'b0011, 2'b01, 1'b1, 1'b0, 1'b0});
        default: expQ.push_back({4'b0011, 2'b00, 1'b0, 1'b1, 1'b1});
      endcase
      @(negedge clk);
      popAndCheck($sformatf("held_c%0d", c), 2);
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
